// File: rtl/block_ram_port_arbiter.sv
// block_ram_port_arbiter
// Shares one port of a byte-enabled block RAM between NUM_REQ requesters.
// Round-robin grant, one single-beat command per cycle, two-stage pipeline
// that routes read data back to the requester that issued the read.
//
// Handshake: a command from requester k transfers in the cycle where
// req_valid_i[k] and req_ready_o[k] are both high. The requester holds valid
// and payload stable until then. req_ready_o is a combinational function of
// req_valid_i and the round-robin pointer, is one-hot or zero, and is low
// while reset is asserted. Responses cannot be stalled: rsp_valid_o pulses
// for one cycle and the addressed requester must take rsp_data_o then.

module block_ram_port_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int ID_WIDTH   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                              clk_i,
    input  logic                              s_rst_n_i,
    input  logic [NUM_REQ-1:0]                req_valid_i,
    output logic [NUM_REQ-1:0]                req_ready_o,
    input  logic [NUM_REQ-1:0]                req_wr_i,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]     req_addr_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]     req_data_i,
    input  logic [NUM_REQ*DATA_WIDTH/8-1:0]   req_be_i,
    output logic [NUM_REQ-1:0]                rsp_valid_o,
    output logic [DATA_WIDTH-1:0]             rsp_data_o,
    output logic                              ram_wr_en_o,
    output logic [ADDR_WIDTH-1:0]             ram_wr_addr_o,
    output logic [DATA_WIDTH-1:0]             ram_data_o,
    output logic [DATA_WIDTH/8-1:0]           ram_wr_byte_valid_o,
    output logic                              ram_rd_en_o,
    output logic [ADDR_WIDTH-1:0]             ram_rd_addr_o,
    input  logic [DATA_WIDTH-1:0]             ram_data_i,
    input  logic                              ram_rd_valid_i
);

    localparam int BE_WIDTH = DATA_WIDTH / 8;

    // Index of the last granted requester; search starts just above it.
    logic [ID_WIDTH-1:0]   rr_ptr;

    logic                  grant_any;
    logic [ID_WIDTH-1:0]   grant_id;
    logic [NUM_REQ-1:0]    grant;

    logic                  sel_wr;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_data;
    logic [BE_WIDTH-1:0]   sel_be;

    // Read-tracking pipeline: stage 1 aligns with the RAM request,
    // stage 2 with the RAM read data.
    logic                  v1;
    logic [ID_WIDTH-1:0]   id1;
    logic                  v2;
    logic [ID_WIDTH-1:0]   id2;

    // Round-robin search from rr_ptr+1 upward with wrap; blocked during reset.
    always_comb begin
        int idx;
        idx       = 0;
        grant_any = 1'b0;
        grant_id  = rr_ptr;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = (int'(rr_ptr) + i) % NUM_REQ;
            if (!grant_any && req_valid_i[idx]) begin
                grant_any = 1'b1;
                grant_id  = ID_WIDTH'(idx);
            end
        end
        if (!s_rst_n_i) begin
            grant_any = 1'b0;
        end
        grant = grant_any ? (NUM_REQ'(1) << grant_id) : '0;
    end

    assign req_ready_o = grant;

    // Payload of the granted requester.
    always_comb begin
        int sel_idx;
        sel_idx  = int'(grant_id);
        sel_wr   = req_wr_i[sel_idx];
        sel_addr = req_addr_i[sel_idx*ADDR_WIDTH +: ADDR_WIDTH];
        sel_data = req_data_i[sel_idx*DATA_WIDTH +: DATA_WIDTH];
        sel_be   = req_be_i[sel_idx*BE_WIDTH +: BE_WIDTH];
    end

    // Stage 1: register the accepted command onto the RAM port and advance the pointer.
    always_ff @(posedge clk_i) begin
        if (!s_rst_n_i) begin
            rr_ptr              <= ID_WIDTH'(NUM_REQ - 1);
            ram_wr_en_o         <= 1'b0;
            ram_wr_addr_o       <= '0;
            ram_data_o          <= '0;
            ram_wr_byte_valid_o <= '0;
            ram_rd_en_o         <= 1'b0;
            ram_rd_addr_o       <= '0;
            v1                  <= 1'b0;
            id1                 <= '0;
        end else begin
            ram_wr_en_o <= grant_any & sel_wr;
            ram_rd_en_o <= grant_any & ~sel_wr;
            v1          <= grant_any & ~sel_wr;
            if (grant_any) begin
                rr_ptr <= grant_id;
                id1    <= grant_id;
                if (sel_wr) begin
                    ram_wr_addr_o       <= sel_addr;
                    ram_data_o          <= sel_data;
                    ram_wr_byte_valid_o <= sel_be;
                end else begin
                    ram_rd_addr_o <= sel_addr;
                end
            end
        end
    end

    // Stage 2: follow the RAM's one-cycle read latency with the requester id.
    always_ff @(posedge clk_i) begin
        if (!s_rst_n_i) begin
            v2  <= 1'b0;
            id2 <= '0;
        end else begin
            v2  <= v1;
            id2 <= id1;
        end
    end

    // v2 gates the RAM's unreset rd_valid so reads dropped by reset never respond.
    assign rsp_valid_o = (v2 && ram_rd_valid_i) ? (NUM_REQ'(1) << id2) : '0;
    assign rsp_data_o  = ram_data_i;

endmodule

// File: tb/tb_block_ram_port_arbiter.sv
// Directed testbench for block_ram_port_arbiter: a two-requester instance
// with a behavioural byte-enabled RAM, plus a four-requester instance used
// for round-robin grant ordering.

module tb_block_ram_port_arbiter;

    int checks   = 0;
    int failures = 0;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    // Two-requester instance
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [1:0]  req_wr;
    logic [19:0] req_addr;
    logic [63:0] req_data;
    logic [7:0]  req_be;
    logic [1:0]  rsp_valid;
    logic [31:0] rsp_data;
    logic        ram_wr_en;
    logic [9:0]  ram_wr_addr;
    logic [31:0] ram_wdata;
    logic [3:0]  ram_be;
    logic        ram_rd_en;
    logic [9:0]  ram_rd_addr;
    logic [31:0] ram_q;
    logic        ram_rd_valid = 1'b0;

    // Four-requester instance
    logic [3:0]   v4     = '0;
    logic [3:0]   r4;
    logic [3:0]   wr4    = '0;
    logic [39:0]  addr4  = '0;
    logic [127:0] data4  = '0;
    logic [15:0]  be4    = '0;
    logic [3:0]   rspv4;
    logic [31:0]  rspd4;
    logic         w_en4;
    logic [9:0]   w_addr4;
    logic [31:0]  w_data4;
    logic [3:0]   w_be4;
    logic         r_en4;
    logic [9:0]   r_addr4;
    logic [31:0]  ramq4  = '0;
    logic         rdv4   = 1'b0;

    logic [31:0] mem [0:1023];
    logic        mem_init = 1'b0;

    always #5 clk = ~clk;

    block_ram_port_arbiter #(.NUM_REQ(2), .DATA_WIDTH(32), .ADDR_WIDTH(10)) dut (
        .clk_i(clk), .s_rst_n_i(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_wr_i(req_wr),
        .req_addr_i(req_addr), .req_data_i(req_data), .req_be_i(req_be),
        .rsp_valid_o(rsp_valid), .rsp_data_o(rsp_data),
        .ram_wr_en_o(ram_wr_en), .ram_wr_addr_o(ram_wr_addr), .ram_data_o(ram_wdata),
        .ram_wr_byte_valid_o(ram_be), .ram_rd_en_o(ram_rd_en), .ram_rd_addr_o(ram_rd_addr),
        .ram_data_i(ram_q), .ram_rd_valid_i(ram_rd_valid)
    );

    block_ram_port_arbiter #(.NUM_REQ(4), .DATA_WIDTH(32), .ADDR_WIDTH(10)) dut4 (
        .clk_i(clk), .s_rst_n_i(rst_n),
        .req_valid_i(v4), .req_ready_o(r4), .req_wr_i(wr4),
        .req_addr_i(addr4), .req_data_i(data4), .req_be_i(be4),
        .rsp_valid_o(rspv4), .rsp_data_o(rspd4),
        .ram_wr_en_o(w_en4), .ram_wr_addr_o(w_addr4), .ram_data_o(w_data4),
        .ram_wr_byte_valid_o(w_be4), .ram_rd_en_o(r_en4), .ram_rd_addr_o(r_addr4),
        .ram_data_i(ramq4), .ram_rd_valid_i(rdv4)
    );

    // Behavioural RAM: byte-enabled write, one-cycle registered read, rd_valid not reset.
    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 1024; i++) mem[i] = 32'hA000_0000 | 32'(i);
            mem[3]   = 32'h1111_1111;
            mem_init = 1'b1;
        end
        if (ram_wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (ram_be[b]) mem[ram_wr_addr][b*8 +: 8] = ram_wdata[b*8 +: 8];
            end
        end
        ram_rd_valid <= ram_rd_en;
        if (ram_rd_en) ram_q <= mem[ram_rd_addr];
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Ready must be one-hot or zero and only where valid is high.
    task automatic settle();
        #1;
        check("rdy_onehot2", 64'($onehot0(req_ready)), 64'd1);
        check("rdy_wo_valid2", 64'(req_ready & ~req_valid), 64'd0);
        check("rdy_onehot4", 64'($onehot0(r4)), 64'd1);
        check("rdy_wo_valid4", 64'(r4 & ~v4), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        ram_q     = '0;
        req_valid = 2'b11;
        req_wr    = 2'b00;
        req_addr  = '0;
        req_data  = '0;
        req_be    = '0;

        // ---- Reset: outputs zero, ready low even with valid high ----
        @(negedge clk);
        @(negedge clk);
        settle();
        check("rst_ready", 64'(req_ready), 64'd0);
        check("rst_wr_en", 64'(ram_wr_en), 64'd0);
        check("rst_rd_en", 64'(ram_rd_en), 64'd0);
        check("rst_rsp", 64'(rsp_valid), 64'd0);
        check("rst_addrs", 64'({ram_wr_addr, ram_rd_addr}), 64'd0);
        check("rst_wdata_be", 64'({ram_wdata, ram_be}), 64'd0);
        check("rst_dut4_a", 64'({w_en4, w_addr4, w_data4, w_be4, r_en4}), 64'd0);
        check("rst_dut4_b", 64'({r_addr4, rspv4, r4, rspd4}), 64'd0);

        // ---- Two readers contend: grants 0,1,0,1 ----
        rst_n          = 1'b1;
        req_addr[9:0]  = 10'h005;
        req_addr[19:10] = 10'h006;
        for (int c = 0; c < 7; c++) begin
            if (c == 4) req_valid = 2'b00;
            settle();
            check("t1_ready", 64'(req_ready),
                  (c < 4) ? ((c % 2 == 0) ? 64'b01 : 64'b10) : 64'b00);
            check("t1_rsp", 64'(rsp_valid),
                  (c >= 2 && c < 6) ? ((c % 2 == 0) ? 64'b01 : 64'b10) : 64'b00);
            if (c >= 2 && c < 6)
                check("t1_data", 64'(rsp_data),
                      (c % 2 == 0) ? 64'hA000_0005 : 64'hA000_0006);
            if (c == 1)
                check("t1_rd_port", 64'({ram_rd_en, ram_rd_addr}), 64'({1'b1, 10'h005}));
            @(negedge clk);
        end

        // ---- Byte-enabled write then read of the same address ----
        req_valid      = 2'b01;
        req_wr         = 2'b01;
        req_addr[9:0]  = 10'h003;
        req_data[31:0] = 32'hDEAD_BEEF;
        req_be[3:0]    = 4'b0101;
        settle();
        check("t2_wr_ready", 64'(req_ready), 64'b01);
        @(negedge clk);
        req_wr = 2'b00;
        settle();
        check("t2_rd_ready", 64'(req_ready), 64'b01);
        check("t2_wr_en", 64'({ram_wr_en, ram_rd_en}), 64'b10);
        check("t2_wr_addr", 64'(ram_wr_addr), 64'h003);
        check("t2_wr_data", 64'(ram_wdata), 64'hDEAD_BEEF);
        check("t2_wr_be", 64'(ram_be), 64'b0101);
        @(negedge clk);
        req_valid = 2'b00;
        settle();
        check("t2_rd_en", 64'({ram_wr_en, ram_rd_en}), 64'b01);
        check("t2_rd_addr", 64'(ram_rd_addr), 64'h003);
        @(negedge clk);
        settle();
        check("t2_rsp", 64'(rsp_valid), 64'b01);
        check("t2_rsp_data", 64'(rsp_data), 64'h11AD_11EF);
        @(negedge clk);
        settle();
        check("t2_rsp_idle", 64'(rsp_valid), 64'b00);

        // ---- Single requester 1 streams six reads back to back ----
        for (int i = 0; i < 8; i++) begin
            if (i < 6) begin
                req_valid       = 2'b10;
                req_addr[19:10] = 10'h010 + 10'(i);
            end else begin
                req_valid = 2'b00;
            end
            settle();
            check("t3_ready", 64'(req_ready), (i < 6) ? 64'b10 : 64'b00);
            check("t3_rsp", 64'(rsp_valid), (i >= 2) ? 64'b10 : 64'b00);
            if (i >= 2)
                check("t3_data", 64'(rsp_data), 64'h0000_0000_A000_0010 + 64'(i - 2));
            @(negedge clk);
        end
        settle();
        check("t3_idle_hold", 64'({ram_rd_en, ram_rd_addr}), 64'({1'b0, 10'h015}));

        // ---- Reset right after a read is accepted: no response ----
        req_valid       = 2'b10;
        req_addr[19:10] = 10'h020;
        settle();
        check("t4_ready", 64'(req_ready), 64'b10);
        @(negedge clk);
        req_valid = 2'b00;
        rst_n     = 1'b0;
        settle();
        check("t4_rd_issued", 64'({ram_rd_en, ram_rd_addr}), 64'({1'b1, 10'h020}));
        @(negedge clk);
        settle();
        check("t4_rsp_dropped", 64'(rsp_valid), 64'b00);
        check("t4_rd_port_rst", 64'({ram_rd_en, ram_rd_addr}), 64'd0);
        req_valid     = 2'b11;
        req_addr[9:0] = 10'h005;
        settle();
        check("t4_ready_in_rst", 64'(req_ready), 64'b00);
        @(negedge clk);
        settle();
        check("t4_rsp_dropped2", 64'(rsp_valid), 64'b00);
        rst_n = 1'b1;
        settle();
        check("t4_first_grant", 64'(req_ready), 64'b01);
        @(negedge clk);
        req_valid = 2'b00;
        settle();
        check("t4_rd_after", 64'({ram_rd_en, ram_rd_addr}), 64'({1'b1, 10'h005}));
        @(negedge clk);
        settle();
        check("t4_rsp_after", 64'(rsp_valid), 64'b01);
        check("t4_data_after", 64'(rsp_data), 64'hA000_0005);

        // ---- Four requesters, 0/2/3 continuously valid ----
        @(negedge clk);
        v4 = 4'b1101;
        for (int i = 0; i < 6; i++) begin
            settle();
            case (i % 3)
                0:       check("t5_grant", 64'(r4), 64'b0001);
                1:       check("t5_grant", 64'(r4), 64'b0100);
                default: check("t5_grant", 64'(r4), 64'b1000);
            endcase
            @(negedge clk);
        end
        v4 = 4'b0000;
        settle();
        check("t5_idle", 64'(r4), 64'b0000);

        // ---- Requester withdraws before grant: ready follows valid ----
        v4 = 4'b1010;
        settle();
        check("t6_grant1", 64'(r4), 64'b0010);
        @(negedge clk);
        v4 = 4'b0010;
        settle();
        check("t6_grant1_again", 64'(r4), 64'b0010);
        @(negedge clk);
        v4 = 4'b0000;
        settle();
        check("t6_none", 64'(r4), 64'b0000);
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/block_ram_port_arbiter.md
Name: block_ram_port_arbiter

Overview:
- Round-robin arbiter that shares one port of the team's byte-enabled dual-port block RAM between NUM_REQ requesters.
- Each requester issues single-beat read or write commands over a valid/ready handshake. Read data is routed back to the requester that issued the read.
- One instance per RAM port. It sits between client engines (DMA, CPU bridge) and the RAM port signals.

Parameters:
- NUM_REQ, 2, number of requesters (2..8)
- DATA_WIDTH, 32, data width in bits; multiple of 8
- ADDR_WIDTH, 10, RAM address width
- ID_WIDTH, $clog2(NUM_REQ) (minimum 1), requester index width

Ports:
- clk_i  in  1  single clock; drives arbiter and RAM port
- s_rst_n_i  in  1  synchronous reset, active-low
- req_valid_i  in  NUM_REQ  per-requester command valid
- req_ready_o  out  NUM_REQ  per-requester command accepted (one-hot or zero)
- req_wr_i  in  NUM_REQ  1 = write, 0 = read
- req_addr_i  in  NUM_REQ*ADDR_WIDTH  packed addresses; requester k at [k*ADDR_WIDTH +: ADDR_WIDTH]
- req_data_i  in  NUM_REQ*DATA_WIDTH  packed write data
- req_be_i  in  NUM_REQ*DATA_WIDTH/8  packed byte enables
- rsp_valid_o  out  NUM_REQ  read data valid, one-hot to the issuing requester
- rsp_data_o  out  DATA_WIDTH  read data, shared by all requesters
- ram_wr_en_o, ram_wr_addr_o, ram_data_o, ram_wr_byte_valid_o  out  1/ADDR_WIDTH/DATA_WIDTH/DATA_WIDTH/8  RAM write controls
- ram_rd_en_o, ram_rd_addr_o  out  1/ADDR_WIDTH  RAM read controls
- ram_data_i, ram_rd_valid_i  in  DATA_WIDTH/1  RAM read data; valid one cycle after ram_rd_en_o

Behaviour:
- **Reset (s_rst_n_i low at a clk_i edge):**
  - All ram_* outputs = 0, req_ready_o = 0, rsp_valid_o = 0.
  - RR pointer = NUM_REQ-1, so requester 0 has highest priority first.
  - In-flight pipeline valid bits are cleared.
- **Handshake:**
  - A command is accepted in cycle T when req_valid_i[k] & req_ready_o[k].
  - A requester must hold valid and its payload stable until accepted.
  - req_ready_o may depend combinationally on req_valid_i. It is never asserted while reset is active.
- **Arbitration:**
  - Grant the first requester with valid set, searching from pointer+1 upward with wrap to 0.
  - At most one grant per cycle. On a grant, pointer <= granted index; with no grant, pointer holds.
  - A continuously valid requester is granted within NUM_REQ cycles.
  - Back-to-back grants are allowed: throughput is one command per cycle.
- **Stage 1 (cycle T+1, registered):**
  - Write command: ram_wr_en_o = 1 with the addr/data/byte-enables of the accepted command; ram_rd_en_o = 0.
  - Read command: ram_rd_en_o = 1 and ram_rd_addr_o = addr; ram_wr_en_o = 0.
  - No command accepted: both enables = 0; address/data outputs hold their previous values.
  - Internal v1 = 1 for reads only; id1 = granted index.
- **Stage 2 (cycle T+2):**
  - v2 <= v1, id2 <= id1.
  - rsp_valid_o[id2] = v2 & ram_rd_valid_i; rsp_data_o = ram_data_i (combinational pass-through).
  - Read latency is 2 cycles from acceptance to rsp_valid_o. No response stall: requesters must always sink rsp.
- **Ordering:**
  - Commands reach the RAM in acceptance order.
  - A read accepted after a write to the same address returns the written bytes.
- **Reset mid-operation:** in-flight reads are dropped. The RAM's unreset rd_valid must not produce rsp_valid_o because the cleared v2 gates it.
- **Byte enables:** passed unmodified; a write with all-zero enables is still issued (the RAM does not change).
- **Unused:** rsp_data_o is undefined when rsp_valid_o = 0.

Test Plan:
- After reset, req 0 and req 1 both hold valid reads to addr 0x005/0x006 for 4 cycles -> grants 0,1,0,1. rsp_valid_o = 01,10,01,10 starting 2 cycles after the first grant, with the matching data.
- Req 0 writes 0xDEADBEEF to addr 0x003 with be=4'b0101, then reads 0x003 the next cycle, RAM pre-filled with 0x11111111 -> read returns 0x11AD11EF.
- Single requester 1 valid for 6 cycles with reads to increasing addresses -> ready every cycle. Responses arrive back-to-back in order with 2-cycle latency.
- Read accepted, then s_rst_n_i pulsed low the next cycle -> no rsp_valid_o is asserted. After reset, requester 0 is granted first.
- NUM_REQ=4 with requesters 0, 2 and 3 continuously valid -> grant sequence 0,2,3,0,2,3. No requester waits more than 3 cycles.
- Requester drops valid without ready (protocol violation excluded); a bench assertion checks req_ready_o is one-hot or zero and never asserted without req_valid_i.
